speed_test_scheduler: RTL
=========================

SPEED_TEST_SCHEDULER -- requirements
Module: speed_test_scheduler

Interface
REQ-001 SHALL have parameter TEST_PORT, default 4, number of test ports.
REQ-002 SHALL have parameter DUR_WIDTH, default 32, width of duration and elapsed counters.
REQ-003 SHALL have parameter READY_TIMEOUT, default 1024, max cycles waited for ready in WAIT_READY or DRAIN.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-006 SHALL have ports: cmd_mask  in  TEST_PORT  ports under test; cmd_duration  in  DUR_WIDTH  run length in cycles.
REQ-007 SHALL have ports: abort  in  1  cancel current test.
REQ-008 SHALL have ports: gen_ready, check_ready  in  TEST_PORT  generator/checker idle per port.
REQ-009 SHALL have ports: start, stop  out  TEST_PORT  one-cycle pulses per port.
REQ-010 SHALL have ports: busy  out  1; done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: done_status  out  2  0=OK, 1=ABORTED, 2=TIMEOUT; elapsed  out  DUR_WIDTH  RUN cycles executed.

Function
REQ-012 SHALL implement states IDLE, WAIT_READY, RUN, STOP, DRAIN, DONE.
REQ-013 SHALL assert cmd_ready only in IDLE; busy high in every state except IDLE.
REQ-014 SHALL, on accept, latch cmd_mask and cmd_duration (0 treated as 1), clear elapsed and status, go to WAIT_READY.
REQ-015 SHALL, if latched mask is 0, go directly to DONE with status OK, elapsed 0, no start/stop issued.
REQ-016 SHALL in WAIT_READY leave when every masked port has gen_ready and check_ready high in the same cycle; unmasked ports ignored.
REQ-017 SHALL in WAIT_READY/DRAIN count cycles; reaching READY_TIMEOUT without condition -> DONE, status TIMEOUT.
REQ-018 SHALL assert start on masked bits only, for exactly the first RUN cycle (cycle T).
REQ-019 SHALL increment elapsed once per RUN cycle; when elapsed reaches duration, go to STOP; stop pulses at cycle T+duration.
REQ-020 SHALL assert stop on masked bits for exactly the single STOP cycle, then go to DRAIN.
REQ-021 SHALL in DRAIN reset timeout counter on entry and go to DONE when all masked check_ready are high.
REQ-022 SHALL pulse done for the single DONE cycle and return to IDLE next cycle.
REQ-023 SHALL hold done_status and elapsed stable from DONE until next command accept.
REQ-024 SHALL on abort in WAIT_READY go to DONE, status ABORTED, no start/stop.
REQ-025 SHALL on abort in RUN (including cycle T) go to STOP next cycle, status ABORTED, elapsed frozen at value reached.
REQ-026 SHALL on abort in STOP/DRAIN record ABORTED and continue normal sequence; abort in IDLE/DONE ignored.
REQ-027 SHALL give ABORTED priority over TIMEOUT when both occur in one cycle.
REQ-028 SHALL never assert start and stop on the same port in the same cycle.

Reset
REQ-029 SHALL on rst go to IDLE next edge regardless of state, without issuing stop.
REQ-030 SHALL reset outputs: cmd_ready 1 (IDLE), busy 0, done 0, start 0, stop 0, done_status 0, elapsed 0; counters and latched mask 0.

Verification
REQ-031 SHALL cover: mask=4'b0101, duration=10, all ready -> start=0101 one cycle at T, stop=0101 at T+10, done status 0, elapsed 10.
REQ-032 SHALL cover: mask=4'b0001, gen_ready[0]=0 forever -> no start, done after 1024 cycles, status 2.
REQ-033 SHALL cover: duration=100, abort at T+5 -> stop at T+6, done status 1, elapsed 6.
REQ-034 SHALL cover: mask=0 -> done 2 cycles after accept, status 0, start/stop never asserted.
REQ-035 SHALL cover: duration=0 -> stop at T+1, elapsed 1, status 0.
REQ-036 SHALL cover: rst asserted mid-RUN -> next cycle IDLE, cmd_ready 1, all outputs at reset values, no stop pulse.

Source files
------------

// File: rtl/speed_test_scheduler.sv
// Sequences a multi-port speed test: wait for ready, start, run for a set
// number of cycles, stop, drain, then report status and elapsed RUN cycles.
module speed_test_scheduler #(
  parameter int TEST_PORT     = 4,
  parameter int DUR_WIDTH     = 32,
  parameter int READY_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [TEST_PORT-1:0] cmd_mask,
  input  logic [DUR_WIDTH-1:0] cmd_duration,
  input  logic                 abort,
  input  logic [TEST_PORT-1:0] gen_ready,
  input  logic [TEST_PORT-1:0] check_ready,
  output logic [TEST_PORT-1:0] start,
  output logic [TEST_PORT-1:0] stop,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_status,
  output logic [DUR_WIDTH-1:0] elapsed
);

  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_ABORT = 2'd1;
  localparam logic [1:0] ST_TMO   = 2'd2;

  typedef enum logic [2:0] {IDLE, WAIT_READY, RUN, STOP, DRAIN, DONE} state_t;

  state_t               state;
  logic [TEST_PORT-1:0] mask;
  logic [DUR_WIDTH-1:0] dur;
  logic [TW-1:0]        tmo;
  logic                 all_ready, drained, timed_out;
  logic [DUR_WIDTH-1:0] elapsed_nxt;

  // Unmasked ports are forced "ready" so they never hold up the sequence.
  assign all_ready   = &((gen_ready & check_ready) | ~mask);
  assign drained     = &(check_ready | ~mask);
  assign timed_out   = (tmo == TW'(READY_TIMEOUT - 1));
  assign elapsed_nxt = elapsed + DUR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      start       <= '0;
      stop        <= '0;
      done_status <= ST_OK;
      elapsed     <= '0;
      mask        <= '0;
      dur         <= '0;
      tmo         <= '0;
    end else begin
      start <= '0;
      stop  <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          mask        <= cmd_mask;
          dur         <= (cmd_duration == '0) ? DUR_WIDTH'(1) : cmd_duration;
          elapsed     <= '0;
          done_status <= ST_OK;
          tmo         <= '0;
          cmd_ready   <= 1'b0;
          busy        <= 1'b1;
          state       <= WAIT_READY;
        end
        WAIT_READY: begin
          if (abort) begin
            done_status <= ST_ABORT;
            done        <= 1'b1;
            state       <= DONE;
          end else if (mask == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (all_ready) begin
            start <= mask;
            state <= RUN;
          end else if (timed_out) begin
            done_status <= ST_TMO;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        RUN: begin
          // The abort cycle still counts as an executed RUN cycle.
          elapsed <= elapsed_nxt;
          if (abort || elapsed_nxt == dur) begin
            if (abort) done_status <= ST_ABORT;
            stop  <= mask;
            state <= STOP;
          end
        end
        STOP: begin
          if (abort) done_status <= ST_ABORT;
          tmo   <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          if (abort) done_status <= ST_ABORT;
          if (drained) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (timed_out) begin
            if (!abort && done_status != ST_ABORT) done_status <= ST_TMO;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
